// File: rtl/fetch_decode_if.sv
// Bus between the fetch/decode sequencer and its surroundings: program ROM,
// board switches and the datapath control lines.
interface fetch_decode_if #(
  parameter int n      = 8,
  parameter int A_SIZE = 2,
  parameter int R_SIZE = 2,
  parameter int P_SIZE = 5
);
  localparam int I_SIZE = 3 + A_SIZE + R_SIZE + n;

  logic [9:0]        SW;
  logic [I_SIZE-1:0] instr;
  logic [P_SIZE-1:0] progAddr;
  logic [A_SIZE-1:0] ALUfunc;
  logic              imm;
  logic              immswitches;
  logic [R_SIZE-1:0] Raddr1;
  logic [n-1:0]      Raddr2;
  logic              regWE;
  logic              halted;
  logic [2:0]        dbg_state;

  // Environment side: drives the switches and ROM data, observes the controls.
  modport master (
    output SW, instr,
    input  progAddr, ALUfunc, imm, immswitches, Raddr1, Raddr2, regWE, halted,
           dbg_state
  );

  // Sequencer side.
  modport slave (
    input  SW, instr,
    output progAddr, ALUfunc, imm, immswitches, Raddr1, Raddr2, regWE, halted,
           dbg_state
  );
endinterface

// File: rtl/fetch_decode.sv
// Instruction fetch/decode sequencer: owns the PC, reads a synchronous ROM,
// decodes datapath controls and runs the SW[8] press/release handshake.
module fetch_decode #(
  parameter int n      = 8,
  parameter int A_SIZE = 2,
  parameter int R_SIZE = 2,
  parameter int P_SIZE = 5
) (
  input logic           clk,
  input logic           nReset,
  fetch_decode_if.slave bus
);
  localparam int I_SIZE = 3 + A_SIZE + R_SIZE + n;

  localparam logic [2:0] OP_RR   = 3'b001;
  localparam logic [2:0] OP_RI   = 3'b010;
  localparam logic [2:0] OP_RS   = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH        = 3'd0,
    S_EXEC         = 3'd1,
    S_WAIT_PRESS   = 3'd2,
    S_WAIT_RELEASE = 3'd3,
    S_HALT         = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [P_SIZE-1:0] pc;
  logic              sw_meta, sw_s;

  logic [2:0]        op;
  logic [A_SIZE-1:0] alu;
  logic [R_SIZE-1:0] rd;
  logic [n-1:0]      operand;

  assign op      = bus.instr[I_SIZE-1 -: 3];
  assign alu     = bus.instr[n+R_SIZE +: A_SIZE];
  assign rd      = bus.instr[n +: R_SIZE];
  assign operand = bus.instr[n-1:0];

  // Enter-button handshake: a switch instruction waits for the synchronised
  // press, writes once, then waits for release so one press gives one write.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sw_meta <= 1'b0;
      sw_s    <= 1'b0;
    end else begin
      sw_meta <= bus.SW[8];
      sw_s    <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // HALT keeps the PC on its own address so a HALT in the last word never wraps.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      pc <= '0;
    end else if (state == S_EXEC && op != OP_HALT) begin
      if (op == OP_JMP) begin
        pc <= operand[P_SIZE-1:0];
      end else begin
        pc <= pc + P_SIZE'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:        state_next = (op == OP_RS) ? S_WAIT_PRESS : S_EXEC;
      S_WAIT_PRESS:   if (sw_s) state_next = S_EXEC;
      S_EXEC: begin
        if (op == OP_RS) begin
          state_next = S_WAIT_RELEASE;
        end else if (op == OP_HALT) begin
          state_next = S_HALT;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_WAIT_RELEASE: if (!sw_s) state_next = S_FETCH;
      S_HALT:         state_next = S_HALT;
      default:        state_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.ALUfunc     = '0;
    bus.imm         = 1'b0;
    bus.immswitches = 1'b0;
    bus.Raddr1      = '0;
    bus.Raddr2      = '0;
    bus.regWE       = 1'b0;
    if (state == S_EXEC || state == S_WAIT_PRESS) begin
      bus.ALUfunc     = alu;
      bus.Raddr1      = rd;
      bus.Raddr2      = operand;
      bus.imm         = (op == OP_RI) || (op == OP_RS);
      bus.immswitches = (op == OP_RS);
    end
    if (state == S_EXEC) begin
      bus.regWE = (op == OP_RR) || (op == OP_RI) || (op == OP_RS);
    end
  end

  assign bus.progAddr  = pc;
  assign bus.halted    = (state == S_HALT);
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: decode table, directed handshake/jump/halt sequences
// and random programs checked against an instruction-level program walker.
module tb_fetch_decode;
  localparam int N = 8, A = 2, R = 2, P = 5, I = 15, W = 14, K = 40;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  fetch_decode_if #(.n(N), .A_SIZE(A), .R_SIZE(R), .P_SIZE(P)) bus ();
  fetch_decode #(.n(N), .A_SIZE(A), .R_SIZE(R), .P_SIZE(P)) dut (
    .clk(clk), .nReset(nReset), .bus(bus)
  );

  logic [I-1:0] rom [32];
  logic [W-1:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  // Synchronous ROM read on the falling edge: data is ready within FETCH.
  always @(negedge clk) bus.instr = rom[bus.progAddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rec_of(input logic [I-1:0] w);
    logic [2:0] op;
    op = w[14:12];
    return {w[11:10], w[9:8], (op == 3'b010 || op == 3'b011), (op == 3'b011), w[7:0]};
  endfunction

  // Scoreboard: every regWE cycle must match the next expected write.
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    if (nReset === 1'b1 && bus.regWE === 1'b1) begin
      act = {bus.ALUfunc, bus.Raddr1, bus.imm, bus.immswitches, bus.Raddr2};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got %0h expected none", act);
      end else begin
        e = exp_q.pop_front();
        check("write", 32'(act), 32'(e));
      end
    end
  end

  task automatic do_reset();
    nReset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nReset = 1'b1;
  endtask

  task automatic step(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = '0;
  endtask

  function automatic logic [I-1:0] rand_instr();
    int r;
    logic [2:0] op;
    r = $urandom_range(0, 19);
    if (r < 4)       op = 3'b000;
    else if (r < 9)  op = 3'b001;
    else if (r < 14) op = 3'b010;
    else if (r < 16) op = 3'b100;
    else if (r == 16) op = 3'b101;
    else if (r == 17) op = 3'b110;
    else if (r == 18) op = 3'b111;
    else             op = 3'b001;
    return {op, 12'($urandom)};
  endfunction

  typedef struct {
    logic [I-1:0] instr;
    logic         we;
    logic [1:0]   alu;
    logic         imm;
    logic         isw;
    logic [1:0]   r1;
    logic [7:0]   r2;
    logic [4:0]   nxt_pc;
    logic         nxt_halt;
  } vec_t;

  vec_t tbl [7];

  initial begin
    bus.SW = '0;
    bus.instr = '0;
    clear_rom();

    tbl[0] = '{15'b000_11_01_10100101, 0, 2'd3, 0, 0, 2'd1, 8'hA5, 5'd1,  0};
    tbl[1] = '{15'b001_10_11_00000010, 1, 2'd2, 0, 0, 2'd3, 8'h02, 5'd1,  0};
    tbl[2] = '{15'b010_00_00_11111111, 1, 2'd0, 1, 0, 2'd0, 8'hFF, 5'd1,  0};
    tbl[3] = '{15'b100_01_10_00010011, 0, 2'd1, 0, 0, 2'd2, 8'h13, 5'd19, 0};
    tbl[4] = '{15'b101_11_11_01010101, 0, 2'd3, 0, 0, 2'd3, 8'h55, 5'd1,  0};
    tbl[5] = '{15'b110_01_01_10000000, 0, 2'd1, 0, 0, 2'd1, 8'h80, 5'd1,  0};
    tbl[6] = '{15'b111_10_01_00001111, 0, 2'd2, 0, 0, 2'd1, 8'h0F, 5'd0,  1};

    // Decode table: each word at ROM[0], checked in its EXEC cycle.
    for (int i = 0; i < 7; i++) begin
      rom[0] = tbl[i].instr;
      if (tbl[i].we) exp_q.push_back({tbl[i].alu, tbl[i].r1, tbl[i].imm, tbl[i].isw, tbl[i].r2});
      do_reset();
      check($sformatf("tbl%0d_fetch_we", i), bus.regWE, 0);
      step(1);
      check($sformatf("tbl%0d_we", i), bus.regWE, tbl[i].we);
      check($sformatf("tbl%0d_alu", i), bus.ALUfunc, tbl[i].alu);
      check($sformatf("tbl%0d_imm", i), bus.imm, tbl[i].imm);
      check($sformatf("tbl%0d_isw", i), bus.immswitches, tbl[i].isw);
      check($sformatf("tbl%0d_r1", i), bus.Raddr1, tbl[i].r1);
      check($sformatf("tbl%0d_r2", i), bus.Raddr2, tbl[i].r2);
      check($sformatf("tbl%0d_halt_exec", i), bus.halted, 0);
      step(1);
      check($sformatf("tbl%0d_pc", i), bus.progAddr, tbl[i].nxt_pc);
      check($sformatf("tbl%0d_halted", i), bus.halted, tbl[i].nxt_halt);
    end

    // Immediate write, switch handshake, jumps, wrap, reset mid-handshake.
    clear_rom();
    rom[0]  = 15'b010_01_10_00000101;
    rom[1]  = 15'b011_00_01_10101010;
    rom[2]  = 15'b100_00_00_00000100;
    rom[3]  = 15'b100_00_00_00011111;
    rom[4]  = 15'b100_00_00_00000011;
    exp_q.push_back(rec_of(rom[0]));
    do_reset();
    check("rst_pc", bus.progAddr, 0);
    check("rst_we", bus.regWE, 0);
    step(1);
    check("imm_we", bus.regWE, 1);
    check("imm_alu", bus.ALUfunc, 1);
    check("imm_imm", bus.imm, 1);
    check("imm_isw", bus.immswitches, 0);
    check("imm_r1", bus.Raddr1, 2);
    check("imm_r2", bus.Raddr2, 8'h05);
    step(1);
    check("imm_next_pc", bus.progAddr, 1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("press_wait_we", bus.regWE, 0);
      check("press_wait_pc", bus.progAddr, 1);
    end
    check("press_wait_isw", bus.immswitches, 1);
    bus.SW[8] = 1'b1;
    exp_q.push_back(rec_of(rom[1]));
    step(2);
    check("press_sync_we", bus.regWE, 0);
    step(1);
    check("sw_we", bus.regWE, 1);
    check("sw_isw", bus.immswitches, 1);
    check("sw_r1", bus.Raddr1, 1);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("hold_we", bus.regWE, 0);
      check("hold_pc", bus.progAddr, 2);
    end
    bus.SW[8] = 1'b0;
    step(3);
    check("release_fetch_we", bus.regWE, 0);
    check("release_pc", bus.progAddr, 2);
    step(1);
    check("jmp2_we", bus.regWE, 0);
    step(1);
    check("jmp2_pc", bus.progAddr, 4);
    step(1);
    check("jmp4_we", bus.regWE, 0);
    step(1);
    check("jmp4_pc", bus.progAddr, 3);
    step(2);
    check("jmp3_pc", bus.progAddr, 31);
    exp_q.push_back(rec_of(rom[0]));
    step(2);
    check("wrap_pc", bus.progAddr, 0);
    step(2);
    check("again_pc", bus.progAddr, 1);
    step(1);
    bus.SW[8] = 1'b1;
    step(1);
    check("pre_rst_we", bus.regWE, 0);
    check("pre_rst_isw", bus.immswitches, 1);
    nReset = 1'b0;
    #1;
    check("arst_pc", bus.progAddr, 0);
    check("arst_we", bus.regWE, 0);
    check("arst_alu", bus.ALUfunc, 0);
    check("arst_imm", bus.imm, 0);
    check("arst_isw", bus.immswitches, 0);
    check("arst_r1", bus.Raddr1, 0);
    check("arst_r2", bus.Raddr2, 0);
    check("arst_halted", bus.halted, 0);
    @(posedge clk);
    @(negedge clk);
    nReset = 1'b1;
    check("post_rst_we", bus.regWE, 0);
    check("post_rst_pc", bus.progAddr, 0);
    exp_q.push_back(rec_of(rom[0]));
    step(1);
    check("post_rst_exec_we", bus.regWE, 1);
    step(2);
    check("held_press_wait_we", bus.regWE, 0);
    exp_q.push_back(rec_of(rom[1]));
    step(1);
    check("held_press_we", bus.regWE, 1);
    bus.SW[8] = 1'b0;
    step(4);

    // HALT at ROM[6] while the switch toggles.
    clear_rom();
    rom[6] = 15'b111_00_00_00000000;
    do_reset();
    step(12);
    check("halt_fetch_pc", bus.progAddr, 6);
    check("halt_pre", bus.halted, 0);
    step(2);
    check("halt_flag", bus.halted, 1);
    check("halt_pc", bus.progAddr, 6);
    for (int i = 0; i < 20; i++) begin
      bus.SW[8] = 1'($urandom_range(0, 1));
      step(1);
      check("halt_hold_we", bus.regWE, 0);
      check("halt_hold_pc", bus.progAddr, 6);
      check("halt_hold_flag", bus.halted, 1);
    end
    bus.SW[8] = 1'b0;
    nReset = 1'b0;
    #1;
    check("halt_rst_flag", bus.halted, 0);
    check("halt_rst_pc", bus.progAddr, 0);

    // HALT in the last word does not wrap; JMP to itself loops.
    clear_rom();
    rom[0]  = 15'b100_00_00_00011111;
    rom[31] = 15'b111_11_11_11111111;
    do_reset();
    step(4);
    check("last_halt_flag", bus.halted, 1);
    check("last_halt_pc", bus.progAddr, 31);
    step(5);
    check("last_halt_hold_pc", bus.progAddr, 31);
    clear_rom();
    rom[5] = 15'b100_11_11_11100101;
    rom[0] = 15'b100_00_00_00000101;
    do_reset();
    step(2);
    for (int i = 0; i < 4; i++) begin
      step(2);
      check("self_jmp_pc", bus.progAddr, 5);
    end

    // Random programs against an instruction-level walker.
    for (int p = 0; p < 6; p++) begin
      logic [4:0] m_pc;
      logic       m_halt;
      logic [2:0] op;
      for (int i = 0; i < 32; i++) rom[i] = rand_instr();
      m_pc = 0;
      m_halt = 0;
      for (int k = 0; k < K && !m_halt; k++) begin
        op = rom[m_pc][14:12];
        case (op)
          3'b001, 3'b010: begin
            exp_q.push_back(rec_of(rom[m_pc]));
            m_pc = 5'((int'(m_pc) + 1) % 32);
          end
          3'b100: m_pc = rom[m_pc][4:0];
          3'b111: m_halt = 1;
          default: m_pc = 5'((int'(m_pc) + 1) % 32);
        endcase
      end
      do_reset();
      step(2 * K);
      check($sformatf("rand%0d_pc", p), bus.progAddr, m_pc);
      check($sformatf("rand%0d_halted", p), bus.halted, m_halt);
      check($sformatf("rand%0d_pending", p), exp_q.size(), 0);
      exp_q.delete();
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
